apb_bank_sequencer: RTL and testbench

//  Sequences APB transfers from decoded SPI commands to the GPIO register banks.

---
 rtl/apb_bank_sequencer.sv | 164 ++++++++++++++++
 tb/tb_apb_bank_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_bank_sequencer.sv
// apb_bank_sequencer
// Turns one decoded SPI command at a time into a full APB SETUP/ACCESS
// transfer on one of BANK_NUM register banks, with wait-state support and
// a bounded wait, and reports read data plus an error flag back to the
// SPI frame logic as a single-cycle response pulse.

module apb_bank_sequencer #(
  parameter  int BANK_NUM   = 2,
  parameter  int DATA_WIDTH = 8,
  parameter  int ADDR_WIDTH = 3,
  parameter  int TIMEOUT    = 15,
  localparam int BANK_IDX_W = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1
) (
  input  logic                  sclk,
  input  logic                  resetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [BANK_IDX_W-1:0] cmd_bank,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy,
  output logic [BANK_NUM-1:0]   b_psel,
  output logic                  b_penable,
  output logic                  b_pwrite,
  output logic [ADDR_WIDTH-1:0] b_paddr,
  output logic [DATA_WIDTH-1:0] b_pwdata,
  input  logic [DATA_WIDTH-1:0] b_prdata,
  input  logic                  b_pready
);

  // The wait counter only has to reach TIMEOUT-1, so this width always
  // leaves headroom for the saturating increment.
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [CNT_W-1:0]      wait_cnt;
  logic [CNT_W-1:0]      wait_cnt_next;
  logic [BANK_NUM-1:0]   psel_next;
  logic                  penable_next;
  logic                  pwrite_next;
  logic [ADDR_WIDTH-1:0] paddr_next;
  logic [DATA_WIDTH-1:0] pwdata_next;
  logic                  rsp_valid_next;
  logic [DATA_WIDTH-1:0] rsp_rdata_next;
  logic                  rsp_err_next;
  logic                  bank_invalid;

  // Ready and busy are decoded straight from the state so they read
  // correctly while reset is still asserted.
  assign cmd_ready    = (state == IDLE);
  assign busy         = (state != IDLE);
  assign bank_invalid = (int'(cmd_bank) >= BANK_NUM);

  // Next-state and next-output decode; every register holds unless a state says otherwise.
  always_comb begin
    state_next     = state;
    wait_cnt_next  = wait_cnt;
    psel_next      = b_psel;
    penable_next   = b_penable;
    pwrite_next    = b_pwrite;
    paddr_next     = b_paddr;
    pwdata_next    = b_pwdata;
    rsp_valid_next = 1'b0;
    rsp_rdata_next = rsp_rdata;
    rsp_err_next   = rsp_err;

    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          pwrite_next   = cmd_write;
          paddr_next    = cmd_addr;
          pwdata_next   = cmd_wdata;
          wait_cnt_next = '0;
          if (bank_invalid) begin
            state_next     = RESP;
            rsp_valid_next = 1'b1;
            rsp_err_next   = 1'b1;
            rsp_rdata_next = '0;
          end else begin
            state_next   = SETUP;
            psel_next    = BANK_NUM'(1) << cmd_bank;
            penable_next = 1'b0;
          end
        end
      end

      SETUP: begin
        state_next   = ACCESS;
        penable_next = 1'b1;
      end

      ACCESS: begin
        // A ready slave wins over the timeout on the same edge.
        if (b_pready) begin
          state_next     = RESP;
          psel_next      = '0;
          penable_next   = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_err_next   = 1'b0;
          rsp_rdata_next = b_pwrite ? '0 : b_prdata;
        end else if (wait_cnt == CNT_LIMIT) begin
          state_next     = RESP;
          psel_next      = '0;
          penable_next   = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_err_next   = 1'b1;
          rsp_rdata_next = '0;
        end else if (wait_cnt != CNT_MAX) begin
          wait_cnt_next = wait_cnt + 1'b1;
        end
      end

      RESP: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and all registered outputs; reset drops the bus and the response at once.
  always_ff @(posedge sclk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      b_psel    <= '0;
      b_penable <= 1'b0;
      b_pwrite  <= 1'b0;
      b_paddr   <= '0;
      b_pwdata  <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_next;
      wait_cnt  <= wait_cnt_next;
      b_psel    <= psel_next;
      b_penable <= penable_next;
      b_pwrite  <= pwrite_next;
      b_paddr   <= paddr_next;
      b_pwdata  <= pwdata_next;
      rsp_valid <= rsp_valid_next;
      rsp_rdata <= rsp_rdata_next;
      rsp_err   <= rsp_err_next;
    end
  end

endmodule

// File: tb/tb_apb_bank_sequencer.sv
// tb_apb_bank_sequencer
// Scoreboard bench: each command pushes its expected response (data, error,
// accept-to-response latency) and a monitor pops and compares on rsp_valid.
// A small APB slave model inserts a programmable number of wait states.

module tb_apb_bank_sequencer;

  localparam int BANK_NUM = 3;
  localparam int DW       = 8;
  localparam int AW       = 3;
  localparam int TIMEOUT  = 15;

  logic          sclk = 1'b0;
  logic          resetn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [1:0]    cmd_bank = '0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          busy;
  logic [BANK_NUM-1:0] b_psel;
  logic          b_penable;
  logic          b_pwrite;
  logic [AW-1:0] b_paddr;
  logic [DW-1:0] b_pwdata;
  logic [DW-1:0] b_prdata = '0;
  logic          b_pready = 1'b0;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int            lat;
    int            acc_cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   slv_waits = 0;
  logic [DW-1:0] slv_rdata = '0;
  int   acc_cnt = 0;
  logic prev_rv = 1'b0;

  apb_bank_sequencer #(
    .BANK_NUM  (BANK_NUM),
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .sclk      (sclk),
    .resetn    (resetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_bank  (cmd_bank),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .b_psel    (b_psel),
    .b_penable (b_penable),
    .b_pwrite  (b_pwrite),
    .b_paddr   (b_paddr),
    .b_pwdata  (b_pwdata),
    .b_prdata  (b_prdata),
    .b_pready  (b_pready)
  );

  // 100 MHz clock
  always #5 sclk = ~sclk;

  // Cycle counter used to measure accept-to-response latency
  always @(posedge sclk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int expLatency(input int waits);
    return (waits < TIMEOUT) ? (2 + waits) : (1 + TIMEOUT);
  endfunction

  // APB slave model: ready after slv_waits ACCESS cycles, read data fixed per test
  always @(negedge sclk) begin
    if (b_penable) begin
      b_pready = (acc_cnt >= slv_waits);
      acc_cnt  = acc_cnt + 1;
    end else begin
      b_pready = 1'b0;
      acc_cnt  = 0;
    end
    b_prdata = slv_rdata;
  end

  // Response monitor: pops the scoreboard on every rsp_valid and compares
  always @(negedge sclk) begin
    if (resetn && rsp_valid) begin
      checkOutput("rsp_pulse_width", 32'(prev_rv), 0);
      checkOutput("rsp_psel_clear", 32'(b_psel), 0);
      checkOutput("rsp_penable_clear", 32'(b_penable), 0);
      checkOutput("rsp_expected", 32'(sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        checkOutput("rsp_rdata", 32'(rsp_rdata), 32'(mon_e.rdata));
        checkOutput("rsp_err", 32'(rsp_err), 32'(mon_e.err));
        checkOutput("rsp_latency", cyc - mon_e.acc_cyc, mon_e.lat);
      end
    end
    prev_rv = resetn && rsp_valid;
  end

  task automatic applyStimulus(input logic wr, input logic [1:0] bank, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rdata,
                               input logic exp_err, input int exp_lat, output int waited);
    exp_t e;
    @(negedge sclk);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_bank  = bank;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    e.rdata   = exp_rdata;
    e.err     = exp_err;
    e.lat     = exp_lat;
    e.acc_cyc = 0;
    sb_q.push_back(e);
    waited = 0;
    while (!cmd_ready && waited < 200) begin
      @(negedge sclk);
      waited++;
    end
    if (!cmd_ready) begin
      checkOutput("accept_timeout", 32'(waited), 0);
      return;
    end
    @(posedge sclk);
    #1;
    sb_q[sb_q.size()-1].acc_cyc = cyc;
  endtask

  task automatic dropValid();
    @(negedge sclk);
    cmd_valid = 1'b0;
  endtask

  task automatic waitDone();
    int n = 0;
    while ((sb_q.size() != 0 || !cmd_ready) && n < 300) begin
      @(negedge sclk);
      n++;
    end
    checkOutput("drain_in_budget", 32'(n < 300), 1);
  endtask

  // Hard stop in case something stalls outside the bounded waits
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence covering reset, waits, timeout, bad bank and back-to-back
  initial begin
    int w1, w2, a1, a2, acc;

    repeat (3) @(negedge sclk);
    checkOutput("reset_cmd_ready", 32'(cmd_ready), 1);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_psel", 32'(b_psel), 0);
    checkOutput("reset_penable", 32'(b_penable), 0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 0);
    checkOutput("reset_rsp_rdata", 32'(rsp_rdata), 0);
    checkOutput("reset_rsp_err", 32'(rsp_err), 0);
    resetn = 1'b1;

    $display("[TB] reset during ACCESS");
    slv_waits = 1000;
    slv_rdata = 8'h44;
    applyStimulus(1'b0, 2'd1, 3'd0, 8'h00, 8'h44, 1'b0, 2, w1);
    dropValid();
    repeat (2) @(negedge sclk);
    checkOutput("pre_reset_penable", 32'(b_penable), 1);
    resetn = 1'b0;
    #1;
    checkOutput("midreset_psel", 32'(b_psel), 0);
    checkOutput("midreset_penable", 32'(b_penable), 0);
    checkOutput("midreset_rsp_valid", 32'(rsp_valid), 0);
    checkOutput("midreset_cmd_ready", 32'(cmd_ready), 1);
    sb_q.delete();
    @(negedge sclk);
    resetn = 1'b1;
    @(negedge sclk);
    checkOutput("postreset_cmd_ready", 32'(cmd_ready), 1);
    checkOutput("postreset_rsp_valid", 32'(rsp_valid), 0);

    $display("[TB] write, zero wait states");
    slv_waits = 0;
    slv_rdata = 8'h77;
    applyStimulus(1'b1, 2'd1, 3'd5, 8'h3C, 8'h00, 1'b0, expLatency(0), w1);
    checkOutput("wr_psel", 32'(b_psel), 32'b010);
    checkOutput("wr_paddr", 32'(b_paddr), 5);
    checkOutput("wr_pwdata", 32'(b_pwdata), 32'h3C);
    checkOutput("wr_pwrite", 32'(b_pwrite), 1);
    checkOutput("wr_penable_setup", 32'(b_penable), 0);
    checkOutput("wr_cmd_ready_busy", 32'(cmd_ready), 0);
    checkOutput("wr_busy", 32'(busy), 1);
    dropValid();
    @(posedge sclk);
    #1;
    checkOutput("wr_penable_access", 32'(b_penable), 1);
    checkOutput("wr_psel_access", 32'(b_psel), 32'b010);
    waitDone();

    $display("[TB] read, two wait states");
    slv_waits = 2;
    slv_rdata = 8'hA5;
    applyStimulus(1'b0, 2'd0, 3'd2, 8'hFF, 8'hA5, 1'b0, expLatency(2), w1);
    checkOutput("rd_psel", 32'(b_psel), 32'b001);
    checkOutput("rd_pwrite", 32'(b_pwrite), 0);
    dropValid();
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge sclk);
      if (b_penable) acc++;
    end
    checkOutput("rd_access_cycles", 32'(acc), 3);
    waitDone();
    repeat (3) @(negedge sclk);
    checkOutput("rd_rdata_hold", 32'(rsp_rdata), 32'hA5);

    $display("[TB] timeout with pready stuck low");
    slv_waits = 1000;
    slv_rdata = 8'h99;
    applyStimulus(1'b0, 2'd0, 3'd7, 8'h00, 8'h00, 1'b1, expLatency(1000), w1);
    dropValid();
    acc = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge sclk);
      if (b_penable) acc++;
    end
    checkOutput("to_access_cycles", 32'(acc), TIMEOUT);
    waitDone();

    $display("[TB] ready on the last allowed cycle");
    slv_waits = TIMEOUT - 1;
    slv_rdata = 8'h5A;
    applyStimulus(1'b0, 2'd2, 3'd3, 8'h00, 8'h5A, 1'b0, expLatency(TIMEOUT - 1), w1);
    checkOutput("edge_psel", 32'(b_psel), 32'b100);
    dropValid();
    waitDone();

    $display("[TB] invalid bank index");
    slv_waits = 0;
    applyStimulus(1'b1, 2'd3, 3'd4, 8'h11, 8'h00, 1'b1, 0, w1);
    checkOutput("bad_psel", 32'(b_psel), 0);
    checkOutput("bad_paddr", 32'(b_paddr), 4);
    dropValid();
    checkOutput("bad_psel_after", 32'(b_psel), 0);
    waitDone();

    $display("[TB] back-to-back held cmd_valid");
    slv_waits = 0;
    slv_rdata = 8'hC3;
    applyStimulus(1'b0, 2'd2, 3'd1, 8'h00, 8'hC3, 1'b0, expLatency(0), w1);
    a1 = cyc;
    applyStimulus(1'b1, 2'd0, 3'd6, 8'h9E, 8'h00, 1'b0, expLatency(0), w2);
    a2 = cyc;
    checkOutput("b2b_ready_low_cycles", 32'(w2), 3);
    checkOutput("b2b_accept_spacing", a2 - a1, 4);
    checkOutput("b2b_psel2", 32'(b_psel), 32'b001);
    checkOutput("b2b_pwdata2", 32'(b_pwdata), 32'h9E);
    dropValid();
    waitDone();
    repeat (6) @(negedge sclk);

    checkOutput("scoreboard_empty", 32'(sb_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
